// File: rtl/lt24_pixel_sink.sv
// lt24_pixel_sink: accepts pixel writes into a small FIFO and serialises them onto the LT24 8080 write bus.
// Defining LT24_SINK_STATS_EN adds a saturating dropCount of discarded out-of-range pixels.
module lt24_pixel_sink #(
  parameter int WIDTH = 240,
  parameter int HEIGHT = 320,
  parameter int WR_CYCLES = 2,
  parameter int FIFO_AW = 2
) (
  input  logic        clock,
  input  logic        globalRst_n,
  input  logic [7:0]  xAddr,
  input  logic [8:0]  yAddr,
  input  logic [15:0] pixelData,
  input  logic        pixelWrite,
  output logic        pixelReady,
  output logic        LT24Wr_n,
  output logic        LT24CS_n,
  output logic        LT24RS,
  output logic [15:0] LT24Data,
  output logic        busy
`ifdef LT24_SINK_STATS_EN
  , output logic [15:0] dropCount
`endif
);
  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int PW = $clog2(2 * WR_CYCLES);
  localparam logic [PW-1:0] HALF = PW'(WR_CYCLES);
  localparam logic [PW-1:0] LAST = PW'(2 * WR_CYCLES - 1);
  localparam logic [15:0] WM1 = 16'(WIDTH - 1);
  localparam logic [15:0] HM1 = 16'(HEIGHT - 1);
  localparam logic [2:0] IDLE = 3'd0, CMD_COL = 3'd1, ARG_COL = 3'd2, CMD_PAGE = 3'd3,
                         ARG_PAGE = 3'd4, CMD_MEMWR = 3'd5, PIXEL = 3'd6;

  logic [32:0] mem [DEPTH];
  logic [FIFO_AW-1:0] wrPtr, rdPtr;
  logic [FIFO_AW:0] count;
  logic [2:0] state, nextState;
  logic [PW-1:0] phase;
  logic [1:0] argIdx;
  logic [7:0] curX, ex, hx, srcX;
  logic [8:0] curY, ey, hy, srcY;
  logic [15:0] curData, hd, argWord, busData;
  logic valid, push, pop, lastPhase, dispatch, outOfRange, sequential, enterPixel;

  assign {hx, hy, hd} = mem[rdPtr];
  assign pixelReady = count != (FIFO_AW + 1)'(DEPTH);
  assign push = pixelWrite && pixelReady;
  assign lastPhase = phase == LAST;
  assign dispatch = state == IDLE || (state == PIXEL && lastPhase);
  assign pop = dispatch && count != '0;
  assign outOfRange = {8'b0, hx} > WM1 || {7'b0, hy} > HM1;
  assign sequential = valid && hx == ex && hy == ey;
  // The expected address is advanced as a pixel enters PIXEL, so a chained pop compares against the post-pixel address
  assign enterPixel = (pop && !outOfRange && sequential) || (state == CMD_MEMWR && lastPhase);
  assign srcX = state == CMD_MEMWR ? curX : hx;
  assign srcY = state == CMD_MEMWR ? curY : hy;
  assign argWord = state == ARG_COL ? (argIdx[1] ? WM1 : {8'b0, curX}) : (argIdx[1] ? HM1 : {7'b0, curY});
  assign busData = state == CMD_COL ? 16'h002A : state == CMD_PAGE ? 16'h002B :
                   state == CMD_MEMWR ? 16'h002C : state == PIXEL ? curData :
                   {8'b0, argIdx[0] ? argWord[7:0] : argWord[15:8]};
  assign busy = count != '0 || state != IDLE || !LT24CS_n;

  always_comb begin
    nextState = state;
    if (pop)
      nextState = outOfRange ? IDLE : sequential ? PIXEL : CMD_COL;
    else if (state == PIXEL && lastPhase)
      nextState = IDLE;
    else if (state != IDLE && lastPhase)
      nextState = (state == ARG_COL || state == ARG_PAGE) && argIdx != 2'd3 ? state : state + 3'd1;
  end

  always_ff @(posedge clock)
    if (push) mem[wrPtr] <= {xAddr, yAddr, pixelData};

  // Bus pins are registered from the FSM, so they trail the state by one clock
  always_ff @(posedge clock or negedge globalRst_n)
    if (!globalRst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      state <= IDLE;
      phase <= '0;
      argIdx <= '0;
      curX <= '0;
      curY <= '0;
      curData <= '0;
      valid <= 1'b0;
      ex <= '0;
      ey <= '0;
      LT24Wr_n <= 1'b1;
      LT24CS_n <= 1'b1;
      LT24RS <= 1'b1;
      LT24Data <= '0;
    end else begin
      wrPtr <= wrPtr + FIFO_AW'(push);
      rdPtr <= rdPtr + FIFO_AW'(pop);
      count <= count + (FIFO_AW + 1)'(push) - (FIFO_AW + 1)'(pop);
      state <= nextState;
      phase <= state == IDLE || lastPhase ? '0 : phase + 1'b1;
      argIdx <= lastPhase && (state == ARG_COL || state == ARG_PAGE) ? argIdx + 2'd1 : argIdx;
      if (pop) {curX, curY, curData} <= {hx, hy, hd};
      if (enterPixel) begin
        valid <= {8'b0, srcX} < WM1 || {7'b0, srcY} < HM1;
        ex <= {8'b0, srcX} < WM1 ? srcX + 8'd1 : 8'd0;
        ey <= {8'b0, srcX} < WM1 ? srcY : srcY + 9'd1;
      end
      LT24CS_n <= state == IDLE;
      LT24Wr_n <= state == IDLE || phase >= HALF;
      if (state != IDLE) begin
        LT24Data <= busData;
        LT24RS <= !(state == CMD_COL || state == CMD_PAGE || state == CMD_MEMWR);
      end
    end

`ifdef LT24_SINK_STATS_EN
  always_ff @(posedge clock or negedge globalRst_n)
    if (!globalRst_n) dropCount <= '0;
    else if (pop && outOfRange && dropCount != 16'hFFFF) dropCount <= dropCount + 16'd1;
`endif
endmodule

// File: tb/tb_lt24_pixel_sink.sv
// tb_lt24_pixel_sink: random and directed pixel traffic checked against a transfer-list model of the LT24 sink.
module tb_lt24_pixel_sink;
  localparam int WIDTH = 240, HEIGHT = 320, WRC = 2, AW = 2;

  logic clock = 1'b0, globalRst_n = 1'b0;
  logic [7:0] xAddr = '0;
  logic [8:0] yAddr = '0;
  logic [15:0] pixelData = '0;
  logic pixelWrite = 1'b0;
  logic pixelReady, LT24Wr_n, LT24CS_n, LT24RS, busy;
  logic [15:0] LT24Data;
`ifdef LT24_SINK_STATS_EN
  logic [15:0] dropCount;
`endif

  lt24_pixel_sink #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .WR_CYCLES(WRC), .FIFO_AW(AW)) dut (
    .clock(clock), .globalRst_n(globalRst_n), .xAddr(xAddr), .yAddr(yAddr),
    .pixelData(pixelData), .pixelWrite(pixelWrite), .pixelReady(pixelReady),
    .LT24Wr_n(LT24Wr_n), .LT24CS_n(LT24CS_n), .LT24RS(LT24RS), .LT24Data(LT24Data), .busy(busy)
`ifdef LT24_SINK_STATS_EN
    , .dropCount(dropCount)
`endif
  );

  always #5 clock = ~clock;

  int checks = 0, errors = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: each accepted pixel expands into its list of {RS,data} transfers
  logic [16:0] expQ[$];
  bit firstQ[$];
  logic [16:0] obsLog[$];
  bit mValid;
  int mEx, mEy;

  task automatic addXfer(input logic [16:0] v, input bit f);
    expQ.push_back(v);
    firstQ.push_back(f);
  endtask

  task automatic modelAccept(input int x, input int y, input logic [15:0] d);
    bit sq;
    if (x >= WIDTH || y >= HEIGHT) return;
    sq = mValid && x == mEx && y == mEy;
    if (!sq) begin
      addXfer(17'h0002A, 1);
      addXfer({1'b1, 16'(x / 256)}, 0);
      addXfer({1'b1, 16'(x % 256)}, 0);
      addXfer({1'b1, 16'((WIDTH - 1) / 256)}, 0);
      addXfer({1'b1, 16'((WIDTH - 1) % 256)}, 0);
      addXfer(17'h0002B, 0);
      addXfer({1'b1, 16'(y / 256)}, 0);
      addXfer({1'b1, 16'(y % 256)}, 0);
      addXfer({1'b1, 16'((HEIGHT - 1) / 256)}, 0);
      addXfer({1'b1, 16'((HEIGHT - 1) % 256)}, 0);
      addXfer(17'h0002C, 0);
    end
    addXfer({1'b1, d}, sq);
    if (x < WIDTH - 1) begin mEx = x + 1; mEy = y; mValid = 1; end
    else if (y < HEIGHT - 1) begin mEx = 0; mEy = y + 1; mValid = 1; end
    else mValid = 0;
  endtask

  int cyc = 0, acc = 0, starts = 0, prevAcc = 0, lowLen = 0, highLen = 0;
  int lastAccEdge = 0, firstFallCyc = -1, sawNotReady = 0;
  bit pend = 0, prevReady = 1, havePrev = 0, prevWr = 1, inXfer = 0, csGap = 0, chkReady = 1;
  logic [16:0] hold;

  always @(negedge clock) begin
    cyc++;
    if (!globalRst_n) begin
      expQ.delete(); firstQ.delete();
      mValid = 0; acc = 0; starts = 0; pend = 0; havePrev = 0; prevWr = 1; inXfer = 0; csGap = 0;
    end else begin
      if (pend) acc++;
      if (!LT24Wr_n && prevWr) begin
        chk("strobeExpected", expQ.size() != 0, 1);
        if (expQ.size() != 0) begin
          chk("xfer", {LT24RS, LT24Data}, expQ[0]);
          if (firstQ[0]) starts++;
          void'(expQ.pop_front());
          void'(firstQ.pop_front());
        end
        if (inXfer && !csGap) chk("wrHighLen", highLen, WRC);
        chk("csLowOnStrobe", LT24CS_n, 0);
        obsLog.push_back({LT24RS, LT24Data});
        if (firstFallCyc < 0) firstFallCyc = cyc;
        hold = {LT24RS, LT24Data};
        lowLen = 1; highLen = 0; inXfer = 1; csGap = 0;
      end else if (!LT24Wr_n) begin
        lowLen++;
        chk("stableLow", {LT24RS, LT24Data}, hold);
      end else if (!prevWr) begin
        chk("wrLowLen", lowLen, WRC);
        chk("stableRise", {LT24RS, LT24Data}, hold);
        highLen = 1;
      end else if (inXfer) begin
        if (LT24CS_n && !csGap) begin
          chk("csHeldThroughHigh", highLen >= WRC, 1);
          csGap = 1;
        end
        if (!csGap && highLen < WRC) chk("stableHigh", {LT24RS, LT24Data}, hold);
        highLen++;
      end
      prevWr = LT24Wr_n;
      if (chkReady && havePrev) chk("pixelReady", prevReady, (prevAcc - starts) != 2 ** AW);
      if (!pixelReady) sawNotReady++;
      prevReady = pixelReady; prevAcc = acc; havePrev = 1;
      pend = pixelWrite && pixelReady && xAddr < WIDTH && yAddr < HEIGHT;
      if (pixelWrite && pixelReady) begin
        modelAccept(int'(xAddr), int'(yAddr), pixelData);
        lastAccEdge = cyc + 1;
      end
    end
  end

  task automatic sendPix(input int x, input int y, input logic [15:0] d);
    int n = 0;
    bit ok;
    xAddr = 8'(x); yAddr = 9'(y); pixelData = d; pixelWrite = 1'b1;
    do begin
      @(negedge clock);
      ok = pixelReady;
      @(posedge clock);
      #1;
      n++;
    end while (!ok && n < 200);
    if (!ok) chk("acceptTimeout", 0, 1);
  endtask

  task automatic drain();
    int n = 0;
    pixelWrite = 1'b0;
    while ((expQ.size() != 0 || busy || !LT24CS_n) && n < 3000) begin
      @(posedge clock);
      #1;
      n++;
    end
    repeat (3) @(posedge clock);
    #1;
    chk("drainBusy", busy, 0);
    chk("drainCs", LT24CS_n, 1);
    chk("drainQueue", expQ.size(), 0);
  endtask

  task automatic chkReset();
    chk("rstWr", LT24Wr_n, 1);
    chk("rstCs", LT24CS_n, 1);
    chk("rstRs", LT24RS, 1);
    chk("rstData", LT24Data, 0);
    chk("rstBusy", busy, 0);
    chk("rstReady", pixelReady, 1);
  endtask

  logic [16:0] t2[12] = '{17'h0002A, 17'h10000, 17'h1000A, 17'h10000, 17'h100EF, 17'h0002B,
                          17'h10000, 17'h10014, 17'h10001, 17'h1003F, 17'h0002C, 17'h1F800};
  logic [16:0] t6[12] = '{17'h0002A, 17'h10000, 17'h10064, 17'h10000, 17'h100EF, 17'h0002B,
                          17'h10000, 17'h100C8, 17'h10001, 17'h1003F, 17'h0002C, 17'h11234};

  initial begin
    int rx, ry;
    repeat (5) @(posedge clock);
    #1;
    chkReset();
    globalRst_n = 1'b1;
    @(posedge clock);
    #1;

    obsLog.delete();
    firstFallCyc = -1;
    sendPix(10, 20, 16'hF800);
    drain();
    chk("t2Count", obsLog.size(), 12);
    for (int i = 0; i < 12; i++) chk($sformatf("t2[%0d]", i), obsLog.size() > i ? obsLog[i] : 'x, t2[i]);
    chk("firstFallLatency", firstFallCyc - lastAccEdge, 2);

    obsLog.delete();
    sendPix(11, 20, 16'h07E0);
    drain();
    chk("seqCount", obsLog.size(), 1);
    chk("seqData", obsLog.size() > 0 ? obsLog[0] : 'x, 17'h107E0);
    sendPix(239, 5, 16'h0001);
    drain();
    obsLog.delete();
    sendPix(0, 6, 16'h0002);
    drain();
    chk("rowWrapCount", obsLog.size(), 1);
    sendPix(239, 319, 16'h0003);
    drain();
    obsLog.delete();
    sendPix(0, 0, 16'h0004);
    drain();
    chk("frameWrapCount", obsLog.size(), 12);

    obsLog.delete();
    sawNotReady = 0;
    for (int i = 0; i < 10; i++) sendPix(50 + i, 7, 16'h0100 + 16'(i));
    drain();
    chk("bpCount", obsLog.size(), 21);
    for (int i = 0; i < 10; i++)
      chk($sformatf("bpOrder[%0d]", i), obsLog.size() > 11 + i ? obsLog[11 + i] : 'x, {1'b1, 16'h0100 + 16'(i)});
    chk("bpSawFull", sawNotReady > 0, 1);

    chkReady = 0;
    obsLog.delete();
    sendPix(240, 0, 16'hAAAA);
    drain();
    chk("oorSilent", obsLog.size(), 0);
    sendPix(0, 0, 16'h5555);
    drain();
    chk("oorNextFull", obsLog.size(), 12);
`ifdef LT24_SINK_STATS_EN
    chk("dropCount", dropCount, 1);
`endif
    chkReady = 1;

    sendPix(5, 5, 16'h0F0F);
    drain();
    obsLog.delete();
    sendPix(100, 200, 16'h1234);
    drain();
    for (int i = 0; i < 12; i++) chk($sformatf("t6[%0d]", i), obsLog.size() > i ? obsLog[i] : 'x, t6[i]);

    sendPix(30, 30, 16'h1111);
    sendPix(200, 100, 16'h2222);
    pixelWrite = 1'b0;
    repeat (9) @(posedge clock);
    #1;
    globalRst_n = 1'b0;
    repeat (5) begin
      @(negedge clock);
      chkReset();
    end
    @(posedge clock);
    #1;
    globalRst_n = 1'b1;
    obsLog.delete();
    sendPix(7, 9, 16'h3333);
    drain();
    chk("postResetFull", obsLog.size(), 12);

    rx = 236; ry = 318;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) < 7) begin
        rx++;
        if (rx == WIDTH) begin rx = 0; ry = ry == HEIGHT - 1 ? 0 : ry + 1; end
      end else begin
        rx = $urandom_range(0, WIDTH - 1);
        ry = $urandom_range(0, HEIGHT - 1);
      end
      sendPix(rx, ry, 16'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        pixelWrite = 1'b0;
        repeat ($urandom_range(1, 20)) @(posedge clock);
        #1;
      end
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lt24_pixel_sink.md
Name: lt24_pixel_sink

Overview:
- Responder end of the pixel-write handshake (xAddr/yAddr/pixelData/pixelWrite/pixelReady) that the scope's pixel generators drive.
- Buffers accepted pixels in a small FIFO and serialises them onto the LT24 8080-style write bus.
- Sequential pixels go out as a single data transfer. A non-sequential pixel first sends the column, page and memory-write command sequence.
- Sits between pixel-producing logic (scope trace, counters) and the LT24 pins. It is a lightweight replacement for full display-driver write paths once panel init is done.

Parameters:
- WIDTH, 240, panel columns; xAddr range 0..WIDTH-1.
- HEIGHT, 320, panel rows; yAddr range 0..HEIGHT-1.
- WR_CYCLES, 2, clocks LT24Wr_n is held low, and then held high, per bus transfer (min 1).
- FIFO_AW, 2, FIFO address width; depth = 2**FIFO_AW.

Ports:
- clock, in, 1, system clock; all logic on posedge.
- globalRst_n, in, 1, asynchronous active-low reset.
- xAddr, in, 8, pixel column.
- yAddr, in, 9, pixel row.
- pixelData, in, 16, RGB565 (15:11 R, 10:5 G, 4:0 B).
- pixelWrite, in, 1, producer write request.
- pixelReady, out, 1, sink can accept; equals FIFO not full.
- LT24Wr_n, out, 1, write strobe, active low.
- LT24CS_n, out, 1, chip select, active low.
- LT24RS, out, 1, 0 = command, 1 = argument/pixel.
- LT24Data, out, 16, bus data.
- busy, out, 1, FIFO non-empty or FSM not IDLE.

Behaviour:
- Reset (async on globalRst_n low, held while low):
  - LT24Wr_n=1, LT24CS_n=1, LT24RS=1, LT24Data=0, busy=0, pixelReady=1.
  - FIFO flushed, FSM=IDLE, expected-address valid flag cleared.
  - Reset mid-transfer aborts immediately; no completion of a partial sequence.
- Accept:
  - A pixel is accepted on a clock where pixelWrite && pixelReady, and is written to the FIFO tail.
  - pixelReady is derived from the registered count. A pop in the same cycle does not raise pixelReady until the next cycle.
  - A push and a pop in the same cycle leave the count unchanged.
- Out-of-range (xAddr>=WIDTH or yAddr>=HEIGHT): accepted, then discarded at pop. There is no bus activity and the expected address is unchanged.
- FSM states: IDLE, CMD_COL, ARG_COL(4), CMD_PAGE, ARG_PAGE(4), CMD_MEMWR, PIXEL.
  - IDLE with FIFO non-empty: pop the head.
    - If valid && (x,y)==(ex,ey), go to PIXEL.
    - Otherwise go to CMD_COL.
  - Sequence values:
    - CMD_COL: 0x2A, RS=0.
    - ARG_COL: x[15:8], x[7:0], (WIDTH-1)[15:8], (WIDTH-1)[7:0], RS=1.
    - CMD_PAGE: 0x2B, RS=0.
    - ARG_PAGE: y hi, y lo, (HEIGHT-1) hi, lo, RS=1.
    - CMD_MEMWR: 0x2C, RS=0.
    - PIXEL: pixelData, RS=1.
  - After PIXEL, return to IDLE. Back-to-back pops chain with no idle gap.
- Bus transfer:
  - LT24Data and LT24RS are set on the first cycle and stable for the whole transfer.
  - LT24Wr_n is low WR_CYCLES clocks, then high WR_CYCLES clocks.
  - Command and argument bytes are zero-extended on LT24Data[15:8].
  - LT24CS_n is low whenever FSM != IDLE.
- Latency:
  - First LT24Wr_n fall is 2 clocks after the accepting clock, for an empty FIFO in IDLE.
  - A sequential pixel costs 2*WR_CYCLES clocks.
  - A non-sequential pixel costs 12 transfers.
- Expected-address update after each PIXEL at (x,y):
  - x<WIDTH-1: ex=x+1, ey=y.
  - x==WIDTH-1, y<HEIGHT-1: ex=0, ey=y+1.
  - x==WIDTH-1, y==HEIGHT-1: valid cleared, so the next pixel always re-sends the window.
  - Valid is set on any PIXEL except the last case.

Optional Feature:
- Macro LT24_SINK_STATS_EN.
- Defined: adds output dropCount[15:0].
  - Reset to 0.
  - Increments on each out-of-range pop.
  - Saturates at 0xFFFF.
- Undefined: port absent; out-of-range pixels are silently discarded. All other behaviour is identical.

Test Plan:
1. Reset: hold globalRst_n low for 5 clocks mid-traffic -> LT24Wr_n=1, LT24CS_n=1, LT24RS=1, LT24Data=0, busy=0, pixelReady=1. After release, the first pixel emits the full 12-transfer sequence.
2. Single pixel (10,20,0xF800), WR_CYCLES=2 -> 12 strobes, each 2 low/2 high:
   - RS0 0x2A; RS1 0x00,0x0A,0x00,0xEF.
   - RS0 0x2B; RS1 0x00,0x14,0x01,0x3F.
   - RS0 0x2C; RS1 0xF800.
   - CS_n high and busy=0 afterwards.
3. Sequential: (11,20,0x07E0) after test 2 -> exactly one strobe, RS=1, data 0x07E0. Row wrap (239,5) then (0,6) -> second pixel is a single transfer. Frame wrap (239,319) then (0,0) -> full 12-transfer sequence.
4. Back-pressure: pixelWrite held high for 10 sequential pixels, FIFO_AW=2 ->
   - pixelReady low exactly when count==4.
   - 10 pixel transfers in order; no loss or duplication.
5. Out-of-range (240,0) then (0,0) -> first produces no bus activity; second produces the full sequence. With LT24_SINK_STATS_EN, dropCount=1.
6. Non-sequential jump (5,5) then (100,200) -> second pixel re-sends the window with args 0x00,0x64,0x00,0xEF / 0x00,0xC8,0x01,0x3F.
